// File: rtl/hit_test_pipe_if.sv
// hit_test_pipe_if: job input bus and hit/tag output bus of hit_test_pipe
//  master drives jobs (v0, v1, v2, p_hit, normal, in_tag, in_empty) and out_rd_en.
//  slave answers with in_rd_en and out_hit, out_tag, out_empty.
//  Vectors are [2:0][W-1:0] with index 0 = x, 1 = y, 2 = z.
interface hit_test_pipe_if #(
  parameter int W = 32,
  parameter int TAG_W = 16
);
  logic [2:0][W-1:0] v0, v1, v2, p_hit, normal;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic in_empty, in_rd_en, out_hit, out_empty, out_rd_en;
  modport master(
    output v0, v1, v2, p_hit, normal, in_tag, in_empty, out_rd_en,
    input in_rd_en, out_hit, out_tag, out_empty
  );
  modport slave(
    input v0, v1, v2, p_hit, normal, in_tag, in_empty, out_rd_en,
    output in_rd_en, out_hit, out_tag, out_empty
  );
endinterface

// File: rtl/hit_test_pipe.sv
// hit_test_pipe: pipelined point-in-triangle test feeding a FWFT {hit, tag} FIFO
//  clock, reset     rising-edge clock, synchronous active-low reset
//  bus (slave)      upstream FWFT job pop and downstream {hit, tag} FIFO pop
//  hit_cnt          saturating count of hits written to the FIFO
//  test_cnt         saturating count of jobs written to the FIFO
module hit_test_pipe #(
  parameter int W = 32,
  parameter int Q_BITS = 10,
  parameter int TAG_W = 16,
  parameter int OUT_DEPTH = 16,
  parameter int INCLUSIVE = 0,
  parameter int CULL = 1,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  hit_test_pipe_if.slave   bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] test_cnt
);
  localparam int AW = $clog2(OUT_DEPTH);
  typedef logic [2:0][W-1:0] vec_t;
  typedef logic signed [2*W-1:0] wide_t;
  function automatic vec_t vsub(input vec_t a, input vec_t b);
    vec_t r;
    for (int i = 0; i < 3; i++) r[i] = a[i] - b[i];
    return r;
  endfunction
  // arithmetic shift by Q_BITS then truncate to W
  function automatic logic [W-1:0] fx(input wide_t s);
    return s[W+Q_BITS-1:Q_BITS];
  endfunction
  function automatic logic [W-1:0] cterm(input logic signed [W-1:0] a, b, c, d);
    return fx(wide_t'(a) * wide_t'(b) - wide_t'(c) * wide_t'(d));
  endfunction
  function automatic vec_t cross3(input vec_t a, input vec_t b);
    vec_t r;
    r[0] = cterm(a[1], b[2], a[2], b[1]);
    r[1] = cterm(a[2], b[0], a[0], b[2]);
    r[2] = cterm(a[0], b[1], a[1], b[0]);
    return r;
  endfunction
  function automatic logic [W-1:0] dot3(input vec_t a, input vec_t b);
    wide_t s;
    s = '0;
    for (int i = 0; i < 3; i++) s = s + wide_t'($signed(a[i])) * wide_t'($signed(b[i]));
    return fx(s);
  endfunction
  vec_t vx [3];
  vec_t e1 [3];
  vec_t w1 [3];
  vec_t c2 [3];
  vec_t n1, n2;
  logic [W-1:0] d3 [3];
  logic [TAG_W-1:0] t1, t2, t3, t4;
  logic s1_v, s2_v, s3_v, s4_v, hit4;
  logic [TAG_W:0] mem [OUT_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [AW+1:0] used;
  logic [2:0] gt, lt, ez;
  logic pos, neg, hit, pop, empty;
  always_comb begin
    vx[0] = bus.v0;
    vx[1] = bus.v1;
    vx[2] = bus.v2;
    gt = '0;
    lt = '0;
    ez = '0;
    for (int i = 0; i < 3; i++) begin
      ez[i] = d3[i] == '0;
      lt[i] = d3[i][W-1];
      gt[i] = !d3[i][W-1] && !ez[i];
    end
    pos = INCLUSIVE != 0 ? &(gt | ez) : &gt;
    neg = INCLUSIVE != 0 ? &(lt | ez) : &lt;
    // a degenerate triangle gives all-zero d and must never hit
    hit = !(&ez) && (pos || (CULL == 0 && neg));
  end
  // credits: every job already popped owns a FIFO slot, so the FIFO cannot overflow
  assign used = (AW+2)'(cnt) + (AW+2)'(s1_v) + (AW+2)'(s2_v) + (AW+2)'(s3_v) + (AW+2)'(s4_v);
  assign bus.in_rd_en = reset && !bus.in_empty && (used < (AW+2)'(OUT_DEPTH));
  assign empty = cnt == '0;
  assign pop = bus.out_rd_en && !empty;
  assign bus.out_empty = empty;
  assign bus.out_hit = !empty && mem[rp][TAG_W];
  assign bus.out_tag = empty ? '0 : mem[rp][TAG_W-1:0];
  always_ff @(posedge clock) begin
    if (!reset) begin
      {s1_v, s2_v, s3_v, s4_v} <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      hit_cnt <= '0;
      test_cnt <= '0;
    end else begin
      s1_v <= bus.in_rd_en;
      s2_v <= s1_v;
      s3_v <= s2_v;
      s4_v <= s3_v;
      if (s4_v) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(s4_v) - (AW+1)'(pop);
      if (s4_v) begin
        test_cnt <= test_cnt + CNT_W'(test_cnt != '1);
        hit_cnt <= hit_cnt + CNT_W'(hit4 && hit_cnt != '1);
      end
    end
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      e1[i] <= vsub(vx[(i + 1) % 3], vx[i]);
      w1[i] <= vsub(bus.p_hit, vx[i]);
      c2[i] <= cross3(e1[i], w1[i]);
      d3[i] <= dot3(n2, c2[i]);
    end
    n1 <= bus.normal;
    n2 <= n1;
    t1 <= bus.in_tag;
    t2 <= t1;
    t3 <= t2;
    t4 <= t3;
    hit4 <= hit;
    if (s4_v) mem[wp] <= {hit4, t4};
  end
endmodule

// File: tb/tb_hit_test_pipe.sv
// tb_hit_test_pipe: directed checks of hit_test_pipe in strict/culling and inclusive/two-sided builds
module tb_hit_test_pipe;
  localparam int W = 32;
  localparam int TW = 16;
  typedef logic [2:0][W-1:0] vec_t;
  typedef struct {
    vec_t v0, v1, v2, p, n;
    logic [TW-1:0] tag;
  } job_t;
  logic clock = 0;
  logic reset = 0;
  always #5 clock = ~clock;
  hit_test_pipe_if #(.W(W), .TAG_W(TW)) ia ();
  hit_test_pipe_if #(.W(W), .TAG_W(TW)) ib ();
  logic [31:0] hca, tca, hcb, tcb;
  hit_test_pipe #(.INCLUSIVE(0), .CULL(1), .OUT_DEPTH(16)) ua (
    .clock(clock), .reset(reset), .bus(ia), .hit_cnt(hca), .test_cnt(tca)
  );
  hit_test_pipe #(.INCLUSIVE(1), .CULL(0), .OUT_DEPTH(4)) ub (
    .clock(clock), .reset(reset), .bus(ib), .hit_cnt(hcb), .test_cnt(tcb)
  );
  job_t jobs [64];
  int n_jobs = 0, ra = 0, rb = 0, cb = 0;
  int checks = 0, errors = 0;
  logic mon = 0;
  assign ia.v0 = jobs[ra].v0;
  assign ia.v1 = jobs[ra].v1;
  assign ia.v2 = jobs[ra].v2;
  assign ia.p_hit = jobs[ra].p;
  assign ia.normal = jobs[ra].n;
  assign ia.in_tag = jobs[ra].tag;
  assign ia.in_empty = ra >= n_jobs;
  assign ib.v0 = jobs[rb].v0;
  assign ib.v1 = jobs[rb].v1;
  assign ib.v2 = jobs[rb].v2;
  assign ib.p_hit = jobs[rb].p;
  assign ib.normal = jobs[rb].n;
  assign ib.in_tag = jobs[rb].tag;
  assign ib.in_empty = rb >= n_jobs;
  always @(posedge clock) begin
    if (ia.in_rd_en) ra <= ra + 1;
    if (ib.in_rd_en) rb <= rb + 1;
    if (!reset) cb <= 0;
    else cb <= cb + int'(ib.in_rd_en) - int'(ib.out_rd_en && !ib.out_empty);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // FIFO slots owned by B (stored + in flight) must be below its depth whenever it pops
  always @(negedge clock) if (mon && ib.in_rd_en) check("credit_b", 64'(cb < 4), 1);
  function automatic vec_t mk(input int x, input int y, input int z);
    vec_t r;
    r[0] = x;
    r[1] = y;
    r[2] = z;
    return r;
  endfunction
  task automatic push(input vec_t a, b, c, p, n, input int t);
    jobs[n_jobs] = '{v0: a, v1: b, v2: c, p: p, n: n, tag: TW'(t)};
    n_jobs++;
  endtask
  task automatic pop(input int u, input logic eh, input int et, input string nm);
    int k = 0;
    while ((u == 0 ? ia.out_empty : ib.out_empty) && k < 20) begin
      @(negedge clock);
      k++;
    end
    check({nm, "_empty"}, u == 0 ? ia.out_empty : ib.out_empty, 0);
    check({nm, "_hit"}, u == 0 ? ia.out_hit : ib.out_hit, eh);
    check({nm, "_tag"}, u == 0 ? ia.out_tag : ib.out_tag, et);
    if (u == 0) ia.out_rd_en = 1;
    else ib.out_rd_en = 1;
    @(negedge clock);
    ia.out_rd_en = 0;
    ib.out_rd_en = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    vec_t o, x1, y1, nz, nn, pin, pout;
    int ra0, rb0;
    o = mk(0, 0, 0);
    x1 = mk('h1000, 0, 0);
    y1 = mk(0, 'h1000, 0);
    nz = mk(0, 0, 'h400);
    nn = mk(0, 0, -'h400);
    pin = mk('h400, 'h400, 0);
    pout = mk('h1400, 'h400, 0);
    ia.out_rd_en = 0;
    ib.out_rd_en = 0;
    repeat (3) @(negedge clock);
    check("rst_empty_a", ia.out_empty, 1);
    check("rst_empty_b", ib.out_empty, 1);
    check("rst_hit_a", ia.out_hit, 0);
    check("rst_tag_a", ia.out_tag, 0);
    check("rst_tcnt_a", tca, 0);
    check("rst_hcnt_b", hcb, 0);
    push(o, x1, y1, pin, nz, 7);
    #1;
    check("rst_rd_en_a", ia.in_rd_en, 0);
    check("rst_rd_en_b", ib.in_rd_en, 0);
    @(negedge clock);
    reset = 1;
    #1;
    check("rd_en_a", ia.in_rd_en, 1);
    check("rd_en_b", ib.in_rd_en, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("lat_early_a", ia.out_empty, 1);
      check("lat_early_b", ib.out_empty, 1);
    end
    @(negedge clock);
    check("lat_a", ia.out_empty, 0);
    check("lat_b", ib.out_empty, 0);
    pop(0, 1, 7, "inside_a");
    pop(1, 1, 7, "inside_b");
    push(o, x1, y1, pout, nz, 2);
    pop(0, 0, 2, "outside_a");
    pop(1, 0, 2, "outside_b");
    check("tcnt_a2", tca, 2);
    check("hcnt_a2", hca, 1);
    push(o, x1, y1, mk('h800, 0, 0), nz, 3);
    pop(0, 0, 3, "edge_a");
    pop(1, 1, 3, "edge_b");
    push(mk('h100, 'h100, 0), mk('h100, 'h100, 0), mk('h100, 'h100, 0), pin, nz, 4);
    pop(0, 0, 4, "degen_a");
    pop(1, 0, 4, "degen_b");
    push(o, x1, y1, pin, nn, 5);
    pop(0, 0, 5, "back_a");
    pop(1, 1, 5, "back_b");
    push(o, mk(0, 'h1000, 0), mk(0, 0, 'h1000), mk(0, 'h400, 'h400), mk('h400, 0, 0), 6);
    pop(0, 1, 6, "yz_in_a");
    pop(1, 1, 6, "yz_in_b");
    push(o, mk(0, 'h1000, 0), mk(0, 0, 'h1000), mk(0, 'h400, -'h400), mk('h400, 0, 0), 8);
    pop(0, 0, 8, "yz_out_a");
    pop(1, 0, 8, "yz_out_b");
    check("tcnt_a7", tca, 7);
    check("hcnt_a7", hca, 2);
    check("tcnt_b7", tcb, 7);
    check("hcnt_b7", hcb, 4);
    ra0 = ra;
    rb0 = rb;
    mon = 1;
    for (int i = 0; i < 10; i++) push(o, x1, y1, i % 2 == 0 ? pin : pout, nz, i);
    repeat (12) @(negedge clock);
    check("full_pops_b", rb - rb0, 4);
    check("full_pops_a", ra - ra0, 10);
    check("full_head_b", ib.out_tag, 0);
    for (int i = 0; i < 10; i++) pop(1, i % 2 == 0, i, "drain_b");
    for (int i = 0; i < 10; i++) pop(0, i % 2 == 0, i, "drain_a");
    mon = 0;
    check("tcnt_b17", tcb, 17);
    check("hcnt_b17", hcb, 9);
    check("hcnt_a17", hca, 7);
    for (int i = 0; i < 3; i++) push(o, x1, y1, pin, nz, 'h11 + i);
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    reset = 1;
    #1;
    check("mid_rst_empty_a", ia.out_empty, 1);
    check("mid_rst_empty_b", ib.out_empty, 1);
    check("mid_rst_tcnt_a", tca, 0);
    check("mid_rst_hcnt_b", hcb, 0);
    check("mid_rst_tag_b", ib.out_tag, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("stale_a", ia.out_empty, 1);
      check("stale_b", ib.out_empty, 1);
    end
    push(o, x1, y1, pin, nz, 'h20);
    pop(0, 1, 'h20, "post_rst_a");
    pop(1, 1, 'h20, "post_rst_b");
    check("post_tcnt_a", tca, 1);
    check("post_hcnt_b", hcb, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
